// File: rtl/encoder16x4.sv
// encoder16x4 - registered 16-to-4 request encoder with valid/ready output.
//
// Request lines are captured into a sticky pending register; the highest
// priority pending bit is issued as a binary index. An accepted index clears
// its pending bit unless it is re-requested in the same cycle (set wins).
//
// Optional build macro: ENCODER16X4_RR_EN
//   undefined - fixed priority, lowest index first
//   defined   - rotating priority; search starts at a pointer that moves to
//               (accepted index + 1) mod 16 on every accept
//
// Parameters:
//   IDLE_CODE  value driven on y while valid is low
// Ports:
//   clk    in   1   clock, rising edge
//   rst_n  in   1   synchronous active-low reset
//   en     in   1   capture enable for req
//   req    in  16   level-sampled request lines
//   ready  in   1   consumer accepts y when valid && ready
//   y      out  4   issued index (registered)
//   valid  out  1   y holds a valid index (registered)
//   pend   out 16   pending register
//   ovf    out  1   sticky: request hit an already-pending, uncleared bit
//
// Output FSM
//   state  | meaning
//   IDLE   | valid=0, y=IDLE_CODE, waiting for any pending bit
//   HOLD   | valid=1, y frozen until ready; back-to-back issue on accept

module encoder16x4 #(
    parameter logic [3:0] IDLE_CODE = 4'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [15:0] req,
    input  logic        ready,
    output logic [3:0]  y,
    output logic        valid,
    output logic [15:0] pend,
    output logic        ovf
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t state;

    logic        accept;
    logic [15:0] clr;
    logic [15:0] req_q;
    logic [15:0] pend_next;
    logic [15:0] rem;
    logic        ovf_hit;
    logic [3:0]  start_idle;
    logic [3:0]  start_hold;

    function automatic logic [15:0] onehot16(input logic [3:0] idx);
        onehot16 = 16'd1 << idx;
    endfunction

    // First set bit found when scanning upward from start, wrapping 15 -> 0.
    // Scanning offsets downward lets the smallest offset overwrite last.
    function automatic logic [3:0] pick(input logic [15:0] v, input logic [3:0] start);
        logic [3:0] idx;
        pick = 4'd0;
        for (int k = 15; k >= 0; k--) begin
            idx = start + 4'(k);
            if (v[idx]) pick = idx;
        end
    endfunction

`ifdef ENCODER16X4_RR_EN
    logic [3:0] rr_ptr;

    // A back-to-back pick searches from the pointer value this accept
    // produces, so the just-accepted index is the lowest priority.
    assign start_idle = rr_ptr;
    assign start_hold = y + 4'd1;
`else
    assign start_idle = 4'd0;
    assign start_hold = 4'd0;
`endif

    always_comb begin
        accept    = valid && ready;
        clr       = accept ? onehot16(y) : 16'd0;
        req_q     = req & {16{en}};
        pend_next = (pend & ~clr) | req_q;
        ovf_hit   = |(req_q & pend & ~clr);
        // Only the bit being accepted is excluded; same-cycle requests are
        // not yet in pend and become visible next cycle.
        rem       = pend & ~onehot16(y);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            pend  <= 16'd0;
            y     <= IDLE_CODE;
            valid <= 1'b0;
            ovf   <= 1'b0;
`ifdef ENCODER16X4_RR_EN
            rr_ptr <= 4'd0;
`endif
        end else begin
            pend <= pend_next;
            if (ovf_hit) ovf <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (|pend) begin
                        y     <= pick(pend, start_idle);
                        valid <= 1'b1;
                        state <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (ready) begin
`ifdef ENCODER16X4_RR_EN
                        rr_ptr <= y + 4'd1;
`endif
                        if (|rem) begin
                            y <= pick(rem, start_hold);
                        end else begin
                            y     <= IDLE_CODE;
                            valid <= 1'b0;
                            state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    y     <= IDLE_CODE;
                    valid <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_encoder16x4.sv
module tb_encoder16x4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [15:0] req;
    logic        ready;
    logic [3:0]  y;
    logic        valid;
    logic [15:0] pend;
    logic        ovf;

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_q[$];

    encoder16x4 #(.IDLE_CODE(4'd0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .req   (req),
        .ready (ready),
        .y     (y),
        .valid (valid),
        .pend  (pend),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Before each edge, an accept (valid && ready) pops the scoreboard and
    // compares the issued index. Outputs are then sampled 1 time unit after
    // the edge.
    task automatic step();
        logic [3:0] e;
        if (valid === 1'b1 && ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_issue observed=%0h expected=none", y);
            end else begin
                e = exp_q.pop_front();
                chk("issue_idx", {12'd0, y}, {12'd0, e});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        exp_q.delete();
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; req = 16'hFFFF; ready = 1'b0;

        // reset holds everything clear even with all requests asserted
        step(); step();
        chk("rst_valid", {15'd0, valid}, 16'd0);
        chk("rst_y", {12'd0, y}, 16'd0);
        chk("rst_pend", pend, 16'd0);
        chk("rst_ovf", {15'd0, ovf}, 16'd0);

        // single pulse on bit 5
        rst_n = 1'b1; req = 16'h0020; ready = 1'b1;
        exp_q.push_back(4'd5);
        step();
        req = 16'h0000;
        chk("p5_pend", pend, 16'h0020);
        chk("p5_valid_early", {15'd0, valid}, 16'd0);
        step();
        chk("p5_valid", {15'd0, valid}, 16'd1);
        chk("p5_y", {12'd0, y}, 16'd5);
        step();
        chk("p5_idle", {15'd0, valid}, 16'd0);
        chk("p5_pend_clr", pend, 16'h0000);

        // 8421 pulse, fresh pointer, continuous ready -> 0,5,10,15
        do_reset();
        ready = 1'b1; req = 16'h8421;
        exp_q.push_back(4'd0); exp_q.push_back(4'd5);
        exp_q.push_back(4'd10); exp_q.push_back(4'd15);
        step();
        req = 16'h0000;
        step();
        for (int i = 0; i < 4; i++) begin
            chk("b2b_valid", {15'd0, valid}, 16'd1);
            step();
        end
        chk("b2b_done", {15'd0, valid}, 16'd0);
        chk("b2b_queue", 16'(exp_q.size()), 16'd0);

        // stall: y frozen while ready low
        ready = 1'b0; req = 16'h0006;
        exp_q.push_back(4'd1); exp_q.push_back(4'd2);
        step();
        req = 16'h0000;
        step();
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", {15'd0, valid}, 16'd1);
            chk("stall_y", {12'd0, y}, 16'd1);
            step();
        end
        ready = 1'b1;
        step();
        chk("stall_next_y", {12'd0, y}, 16'd2);
        step();
        chk("stall_done", {15'd0, valid}, 16'd0);

        // en low blocks capture; one enabled cycle fills all 16
        do_reset();
        en = 1'b0; req = 16'hFFFF; ready = 1'b1;
        step(); step(); step();
        chk("en0_pend", pend, 16'h0000);
        chk("en0_valid", {15'd0, valid}, 16'd0);
        en = 1'b1;
        for (int i = 0; i < 16; i++) exp_q.push_back(4'(i));
        step();
        en = 1'b0;
        chk("all_pend", pend, 16'hFFFF);
        step();
        for (int i = 0; i < 16; i++) begin
            chk("all_valid", {15'd0, valid}, 16'd1);
            step();
        end
        chk("all_done", {15'd0, valid}, 16'd0);
        chk("all_pend_clr", pend, 16'h0000);
        chk("all_ovf", {15'd0, ovf}, 16'd0);

        // overflow on re-request of a pending bit, then reset mid-hold
        en = 1'b1; ready = 1'b0; req = 16'h0008;
        exp_q.push_back(4'd3);
        step();
        chk("ovf_first", {15'd0, ovf}, 16'd0);
        step();
        chk("ovf_set", {15'd0, ovf}, 16'd1);
        chk("ovf_hold_y", {12'd0, y}, 16'd3);
        req = 16'h0000; rst_n = 1'b0;
        step();
        chk("midrst_valid", {15'd0, valid}, 16'd0);
        chk("midrst_ovf", {15'd0, ovf}, 16'd0);
        chk("midrst_pend", pend, 16'h0000);
        rst_n = 1'b1;
        exp_q.delete();

        // accept and re-request in the same cycle: stays pending, no ovf
        ready = 1'b1; req = 16'h0010;
        exp_q.push_back(4'd4);
        step();
        req = 16'h0000;
        step();
        chk("rereq_y", {12'd0, y}, 16'd4);
        req = 16'h0010;
        exp_q.push_back(4'd4);
        step();
        req = 16'h0000;
        chk("rereq_pend", pend, 16'h0010);
        chk("rereq_ovf", {15'd0, ovf}, 16'd0);
        step();
        chk("rereq_valid2", {15'd0, valid}, 16'd1);
        chk("rereq_y2", {12'd0, y}, 16'd4);
        step();
        chk("rereq_done", {15'd0, valid}, 16'd0);
        chk("final_queue", 16'(exp_q.size()), 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/encoder16x4.md
# encoder16x4

Registered 16-to-4 request encoder, the return path for the team's 4x16 one-hot decoders. Sixteen request lines are captured into sticky pending bits and the highest-priority pending bit is issued as a 4-bit index over a valid/ready handshake. An accepted index clears its pending bit. The block sits between interrupt or request sources and a consumer that services one index at a time.

## Interface
- `IDLE_CODE`, default `4'd0`: value driven on `y` whenever `valid` is low.
- `clk` input 1: the single clock; all state updates on its rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `en` input 1: capture enable; when low, `req` is ignored.
- `req` input 16: request lines, level-sampled each cycle; bit i requests index i.
- `y` output 4: issued index (binary), registered.
- `valid` output 1: `y` holds a valid index, registered.
- `ready` input 1: consumer accepts `y` in any cycle where `valid && ready`.
- `pend` output 16: current pending register, for status and debug.
- `ovf` output 1: sticky flag set when a request hits an already-pending bit; cleared only by reset.

## Operation
- Pending register P has 16 bits.
  - Each cycle: `P_next = (P & ~clr) | (req & {16{en}})`.
  - `clr` is the one-hot of `y` when `valid && ready`, otherwise 0.
  - Set wins over clear: a bit that is re-requested in its accept cycle stays pending and is issued again later.
- Winner selection operates on the registered P, never on `req` directly. Default priority is fixed: lowest index wins (bit 0 highest).
- Output FSM states:
  - IDLE (`valid`=0): if `P != 0`, load `y` = winner(P), go to HOLD; otherwise stay.
  - HOLD (`valid`=1), `ready`=0: `y` is frozen and stays in HOLD, even if a higher-priority bit becomes pending.
  - HOLD, `ready`=1: let `R = P & ~onehot(y)`. If `R != 0`, load `y` = winner(R) and stay in HOLD (back-to-back). Otherwise go to IDLE with `y` = `IDLE_CODE`.
- Winner selection in HOLD excludes only the bit being accepted. Requests arriving in the accept cycle become visible one cycle later.
- `ovf`: set when, for any i, `en && req[i] && P[i] && !clr[i]`.
- `en` low blocks capture only. Already-pending bits continue to drain normally.
- Reset (applies at any time, including mid-handshake) sets:
  - P = 0, `valid` = 0, `y` = `IDLE_CODE`, `ovf` = 0, state = IDLE, rotate pointer = 0.
  - Any in-flight index is discarded.

## Timing
- All outputs are registered. `y`, `valid`, `pend` and `ovf` change only on the rising edge of `clk`.
- Latency:
  - `req[i]` high at edge t is reflected in `pend[i]` after edge t.
  - From IDLE, `valid` and `y` = i appear after edge t+1. Request to valid is 2 cycles.
- Throughput: one index per cycle while `ready` is held high and P stays non-zero.
- `ready` is ignored while `valid`=0. The consumer may hold `ready` high continuously.
- `y` must not change while `valid && !ready`.
- Simultaneous events:
  - Accept of bit i and new `req[i]` in the same cycle: bit i stays pending and `ovf` is not set.
  - `req` asserted on a bit that is pending and not being cleared: `ovf` = 1 from the next edge.
- Boundary case, all 16 bits pending with continuous `ready`: indices are issued in 16 consecutive cycles, then the FSM returns to IDLE.

## Configuration
- Macro: `ENCODER16X4_RR_EN`.
- Defined: rotating priority.
  - A 4-bit pointer selects the first index searched; the search wraps 15 to 0.
  - On each accept, pointer = `y` + 1 mod 16, so accepting index 15 sets the pointer to 0.
  - Reset sets the pointer to 0.
- Undefined: the pointer logic is absent and priority is fixed lowest-index-first.
- All other behaviour is identical in both builds.

## Test plan
- Reset with `req`=16'hFFFF, `en`=1, `rst_n`=0 -> while in reset: `valid`=0, `y`=`IDLE_CODE`, `pend`=0, `ovf`=0.
- Single pulse `req`=16'h0020 for one cycle, `ready`=1 -> `pend`=16'h0020 one cycle later; `valid`=1, `y`=5 the cycle after that; then `valid`=0 and `pend`=0.
- `req`=16'h8421 pulsed once, `ready`=1 continuously -> fixed build issues 0, 5, 10, 15 in consecutive cycles; RR build from pointer 0 gives the same order.
- `req`=16'h0006 pulsed, `ready`=0 for 5 cycles -> `y`=1 held stable for all 5 cycles; after `ready` rises, `y`=2 on the next cycle.
- `en`=0 with `req`=16'hFFFF -> `pend` stays 0 and `valid` stays 0; raising `en` for one cycle -> `pend`=16'hFFFF, then 16 back-to-back issues.
- `req[3]` held high while index 3 is pending and `ready`=0 -> `ovf`=1 one cycle after the second sample; reset mid-HOLD -> `valid`=0 and `ovf`=0 on the following edge.
